// File: rtl/counter_mod_prog.sv
// Programmable modulo-M up/down counter with a shadowed modulus.
// It supports preload, synchronous clear, one-shot stop and a cascade carry.
module counter_mod_prog #(
    parameter int WIDTH       = 10,
    parameter int DEFAULT_MOD = 1000
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic             sclr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    input  logic             oneshot,
    input  logic             mod_wr,
    input  logic [WIDTH-1:0] mod_in,
    output logic [WIDTH-1:0] q,
    output logic             co,
    output logic             done,
    output logic [WIDTH-1:0] mod_q,
    output logic             mod_err
);

    if (DEFAULT_MOD < 1 || DEFAULT_MOD > (2 ** WIDTH) - 1) begin : g_bad_mod
        $error("counter_mod_prog: DEFAULT_MOD out of range");
    end

    localparam logic [WIDTH-1:0] MOD_RST = WIDTH'(DEFAULT_MOD);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] act_mod_q, act_mod_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mod_next;
    logic             tc;
    logic             xfer;

    // Modulus that becomes active if a transfer happens on this edge
    assign mod_next = pend_q ? shadow_q : act_mod_q;
    assign tc       = dir ? (q_q == '0) : (q_q == act_mod_q - ONE);

    always_comb begin
        q_d       = q_q;
        done_d    = done_q;
        act_mod_d = act_mod_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        err_d     = err_q;
        xfer      = 1'b0;
        if (sclr) begin
            xfer   = 1'b1;
            q_d    = dir ? mod_next - ONE : '0;
            done_d = 1'b0;
        end else if (ld) begin
            q_d    = (d < act_mod_q) ? d : act_mod_q - ONE;
            done_d = 1'b0;
        end else if (en && !done_q) begin
            if (!tc) begin
                q_d = dir ? q_q - ONE : q_q + ONE;
            end else if (!oneshot) begin
                xfer = 1'b1;
                q_d  = dir ? mod_next - ONE : '0;
            end else begin
                done_d = 1'b1;
            end
        end
        if (xfer) begin
            act_mod_d = mod_next;
            pend_d    = 1'b0;
        end
        // A write on a transfer edge lands in the shadow for the next wrap
        if (mod_wr) begin
            if (mod_in != '0) begin
                shadow_d = mod_in;
                pend_d   = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            q_q       <= '0;
            done_q    <= 1'b0;
            act_mod_q <= MOD_RST;
            shadow_q  <= MOD_RST;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            q_q       <= q_d;
            done_q    <= done_d;
            act_mod_q <= act_mod_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
        end
    end

    // Gated by r so the carry stays quiet while the chain is held in reset
    assign co      = en & tc & ~sclr & ~ld & ~done_q & r;
    assign q       = q_q;
    assign done    = done_q;
    assign mod_q   = act_mod_q;
    assign mod_err = err_q;

endmodule

// File: tb/tb_counter_mod_prog.sv
// Directed, table-driven bench for counter_mod_prog.
// Covers wrap, down count, preload, modulus shadowing, one-shot and async reset.
module tb_counter_mod_prog;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         r   = 1'b0;
    logic         en = 1'b0, sclr = 1'b0, ld = 1'b0, dir = 1'b0;
    logic         oneshot = 1'b0, mod_wr = 1'b0;
    logic [W-1:0] d = '0, mod_in = '0;
    logic [W-1:0] q, mod_q;
    logic         co, done, mod_err;

    int n_chk = 0;
    int n_err = 0;

    counter_mod_prog #(.WIDTH(W), .DEFAULT_MOD(1000)) dut (
        .clk(clk), .r(r), .en(en), .sclr(sclr), .ld(ld), .d(d),
        .dir(dir), .oneshot(oneshot), .mod_wr(mod_wr), .mod_in(mod_in),
        .q(q), .co(co), .done(done), .mod_q(mod_q), .mod_err(mod_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         en, sclr, ld, dir, os, wr;
        logic [W-1:0] d, min;
        logic         e_co;
        int           e_q;
        logic         e_done;
        int           e_mod;
        logic         e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic e, logic s, logic l, int dd, logic dr, logic o, logic w,
        int mi, logic eco, int eq, logic edn, int emod, logic eerr);
        vec_t v;
        v.en = e; v.sclr = s; v.ld = l; v.d = W'(dd); v.dir = dr;
        v.os = o; v.wr = w; v.min = W'(mi);
        v.e_co = eco; v.e_q = eq; v.e_done = edn;
        v.e_mod = emod; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        en = v.en; sclr = v.sclr; ld = v.ld; d = v.d; dir = v.dir;
        oneshot = v.os; mod_wr = v.wr; mod_in = v.min;
        #1;
        chk($sformatf("v%0d co", idx), int'(co), int'(v.e_co));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d q", idx), int'(q), v.e_q);
        chk($sformatf("v%0d done", idx), int'(done), int'(v.e_done));
        chk($sformatf("v%0d mod_q", idx), int'(mod_q), v.e_mod);
        chk($sformatf("v%0d mod_err", idx), int'(mod_err), int'(v.e_err));
    endtask

    task automatic idle_drive();
        en = 1'b0; sclr = 1'b0; ld = 1'b0; mod_wr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int co_cnt;
        // en sclr ld d dir os wr min | co q done mod err
        vecs.push_back(mk(0,1,0,  0,1,0,0, 0, 0,999,0,1000,0));
        vecs.push_back(mk(1,0,0,  0,1,0,0, 0, 0,998,0,1000,0));
        vecs.push_back(mk(1,0,0,  0,1,0,0, 0, 0,997,0,1000,0));
        vecs.push_back(mk(1,0,0,  0,1,0,0, 0, 0,996,0,1000,0));
        vecs.push_back(mk(1,0,0,  0,1,0,0, 0, 0,995,0,1000,0));
        vecs.push_back(mk(1,0,0,  0,1,0,0, 0, 0,994,0,1000,0));
        vecs.push_back(mk(1,0,1,  1,1,0,0, 0, 0,  1,0,1000,0));
        vecs.push_back(mk(1,0,0,  0,1,0,0, 0, 0,  0,0,1000,0));
        vecs.push_back(mk(1,0,0,  0,1,0,0, 0, 1,999,0,1000,0));
        vecs.push_back(mk(0,0,1,500,0,0,0, 0, 0,500,0,1000,0));
        vecs.push_back(mk(0,0,0,  0,0,0,1,10, 0,500,0,1000,0));
        vecs.push_back(mk(0,0,1,998,0,0,0, 0, 0,998,0,1000,0));
        vecs.push_back(mk(1,0,0,  0,0,0,0, 0, 0,999,0,1000,0));
        vecs.push_back(mk(1,0,0,  0,0,0,0, 0, 1,  0,0,  10,0));

        idle_drive();
        dir = 1'b0; oneshot = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset q", int'(q), 0);
        chk("reset done", int'(done), 0);
        chk("reset mod_q", int'(mod_q), 1000);
        chk("reset mod_err", int'(mod_err), 0);
        chk("reset co", int'(co), 0);
        r = 1'b1;
        en = 1'b1;

        co_cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            #1;
            chk($sformatf("run q@%0d", i), int'(q), i % 1000);
            chk($sformatf("run co@%0d", i), int'(co), int'((i % 1000) == 999));
            if (co) co_cnt++;
            @(posedge clk);
        end
        #1;
        chk("run co pulses", co_cnt, 2);
        chk("run mod_q", int'(mod_q), 1000);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        for (int i = 0; i < 10; i++) begin
            apply(mk(1,0,0,0,0,0,0,0, logic'(i == 9), (i + 1) % 10, 0, 10, 0),
                  100 + i);
        end

        vecs.delete();
        vecs.push_back(mk(0,0,0,0,0,0,1,7, 0,0,0,10,0));
        vecs.push_back(mk(0,1,0,0,0,0,1,4, 0,0,0, 7,0));
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 0,0,0, 4,0));
        vecs.push_back(mk(1,0,0,0,0,1,0,0, 0,1,0, 4,0));
        vecs.push_back(mk(1,0,0,0,0,1,0,0, 0,2,0, 4,0));
        vecs.push_back(mk(1,0,0,0,0,1,0,0, 0,3,0, 4,0));
        vecs.push_back(mk(1,0,0,0,0,1,0,0, 1,3,1, 4,0));
        vecs.push_back(mk(1,0,0,0,0,1,0,0, 0,3,1, 4,0));
        vecs.push_back(mk(1,0,1,7,0,1,0,0, 0,3,0, 4,0));
        vecs.push_back(mk(1,0,0,0,0,1,0,0, 1,3,1, 4,0));
        vecs.push_back(mk(0,0,0,0,0,1,1,0, 0,3,1, 4,1));
        vecs.push_back(mk(0,0,0,0,0,1,1,1, 0,3,1, 4,1));
        vecs.push_back(mk(1,1,0,0,0,0,0,0, 0,0,0, 1,1));
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0, 1,1));
        vecs.push_back(mk(1,0,0,0,1,0,0,0, 1,0,0, 1,1));
        vecs.push_back(mk(0,0,0,0,1,0,0,0, 0,0,0, 1,1));
        vecs.push_back(mk(0,0,0,0,0,0,1,8, 0,0,0, 1,1));
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 0,0,0, 8,1));
        vecs.push_back(mk(0,0,1,7,0,0,0,0, 0,7,0, 8,1));
        vecs.push_back(mk(1,0,0,0,0,1,0,0, 1,7,1, 8,1));
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 200 + i);

        #1;
        chk("pre-reset q", int'(q), 7);
        chk("pre-reset done", int'(done), 1);
        #1;
        r = 1'b0;
        en = 1'b1; dir = 1'b1; oneshot = 1'b0;
        #1;
        chk("async q", int'(q), 0);
        chk("async done", int'(done), 0);
        chk("async mod_q", int'(mod_q), 1000);
        chk("async mod_err", int'(mod_err), 0);
        chk("async co", int'(co), 0);
        @(posedge clk);
        #1;
        chk("held q", int'(q), 0);
        dir = 1'b0;
        r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("restart q%0d", i), int'(q), i);
            @(posedge clk);
        end
        #1;
        chk("restart mod_q", int'(mod_q), 1000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
